// File: rtl/game_pkg.sv
// Shared game types and default timing constants for the player freeze controllers.
// All cycle defaults assume a 100 MHz system clock.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FROZEN = 2'b01,
    ST_GRACE  = 2'b10
  } freeze_state_e;

  localparam int unsigned FREEZE_CYCLES_DEF = 300_000_000;
  localparam int unsigned GRACE_CYCLES_DEF  = 100_000_000;
  localparam int unsigned BLINK_DIV_DEF     = 5_000_000;
  localparam int unsigned CNT_W_DEF         = 29;

endpackage

// File: rtl/blue_freeze_ctrl_rise_edge.sv
// 1-bit registered rising-edge detector with synchronous active-high reset.
// rise_c is combinational: level high now and low on the previous clock.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/blue_freeze_ctrl.sv
// Blue player freeze controller: IDLE -> FROZEN -> GRACE -> IDLE, gating movement requests.
// Optional sprite blink during GRACE is enabled by defining FREEZE_BLINK_EN.
module blue_freeze_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FREEZE_CYCLES = FREEZE_CYCLES_DEF,
  parameter int unsigned GRACE_CYCLES  = GRACE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned BLINK_DIV     = BLINK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic hit,
  input  logic req_left,
  input  logic req_right,
  input  logic req_jump,
  output logic mv_left,
  output logic mv_right,
  output logic mv_jump,
  output logic frozen,
  output logic immune,
  output logic blink
);

  // Elaboration-time parameter sanity checks
  if (FREEZE_CYCLES < 1 || GRACE_CYCLES < 1) begin : g_bad_cycles
    $error("blue_freeze_ctrl: FREEZE_CYCLES and GRACE_CYCLES must be >= 1");
  end
  if (longint'(FREEZE_CYCLES) > (longint'(1) << CNT_W) ||
      longint'(GRACE_CYCLES)  > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("blue_freeze_ctrl: CNT_W too narrow for the cycle counts");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("blue_freeze_ctrl: BLINK_DIV must be >= 1");
  end

  logic          trigger_c;
  freeze_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic          frozen_n, immune_n, move_en_n;

  rise_edge u_hit_edge (
    .clk    (clk),
    .rst    (rst),
    .level  (hit),
    .rise_c (trigger_c)
  );

  // Next state, shared down-counter and next registered outputs
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    frozen_n  = 1'b0;
    immune_n  = 1'b0;
    move_en_n = 1'b1;
    case (state)
      ST_IDLE: begin
        if (trigger_c) begin
          state_n = ST_FROZEN;
          cnt_n   = CNT_W'(FREEZE_CYCLES - 1);
        end
      end
      ST_FROZEN: begin
        if (cnt == '0) begin
          state_n = ST_GRACE;
          cnt_n   = CNT_W'(GRACE_CYCLES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_GRACE: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    frozen_n  = (state_n == ST_FROZEN);
    immune_n  = (state_n == ST_GRACE);
    move_en_n = (state_n != ST_FROZEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      frozen   <= 1'b0;
      immune   <= 1'b0;
      mv_left  <= 1'b0;
      mv_right <= 1'b0;
      mv_jump  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      frozen   <= frozen_n;
      immune   <= immune_n;
      mv_left  <= req_left  & move_en_n;
      mv_right <= req_right & move_en_n;
      mv_jump  <= req_jump  & move_en_n;
    end
  end

`ifdef FREEZE_BLINK_EN
  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] div;

  // Blink starts low on GRACE entry and toggles every BLINK_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      blink <= 1'b1;
    end else if (state_n == ST_GRACE) begin
      if (state != ST_GRACE) begin
        div   <= '0;
        blink <= 1'b0;
      end else if (div == DIV_W'(BLINK_DIV - 1)) begin
        div   <= '0;
        blink <= ~blink;
      end else begin
        div <= div + DIV_W'(1);
      end
    end else begin
      div   <= '0;
      blink <= 1'b1;
    end
  end
`else
  assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_blue_freeze_ctrl.sv
// Directed self-checking bench for blue_freeze_ctrl with FREEZE=8, GRACE=4, BLINK_DIV=2.
module tb_blue_freeze_ctrl;

  logic clk = 1'b0;
  logic rst, hit, req_left, req_right, req_jump;
  logic mv_left, mv_right, mv_jump, frozen, immune, blink;

  int n_checks = 0;
  int n_errors = 0;

  blue_freeze_ctrl #(
    .FREEZE_CYCLES (8),
    .GRACE_CYCLES  (4),
    .CNT_W         (4),
    .BLINK_DIV     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .req_left  (req_left),
    .req_right (req_right),
    .req_jump  (req_jump),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .mv_jump   (mv_jump),
    .frozen    (frozen),
    .immune    (immune),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge, then settle past it before driving/sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic blink_exp(input int g);
`ifdef FREEZE_BLINK_EN
    return (g >= 2);
`else
    return 1'b1 | logic'(g[31]);
`endif
  endfunction

  // Step k=0 samples the triggering edge; k=0..7 frozen, 8..11 grace, 12 idle.
  // hit is high for k<hold and additionally at k==rh1 / k==rh2.
  task automatic freeze_seq(input string tag, input int hold, input int rh1, input int rh2);
    for (int k = 0; k < 13; k++) begin
      hit = (k < hold) || (k == rh1) || (k == rh2);
      step();
      if (k < 8) begin
        chk({tag, "_frozen"}, frozen, 1'b1);
        chk({tag, "_immune_f"}, immune, 1'b0);
        chk({tag, "_mvr_f"}, mv_right, 1'b0);
        chk({tag, "_blink_f"}, blink, 1'b1);
      end else if (k < 12) begin
        chk({tag, "_frozen_g"}, frozen, 1'b0);
        chk({tag, "_immune"}, immune, 1'b1);
        chk({tag, "_mvr_g"}, mv_right, 1'b1);
        chk({tag, "_blink_g"}, blink, blink_exp(k - 8));
      end else begin
        chk({tag, "_frozen_end"}, frozen, 1'b0);
        chk({tag, "_immune_end"}, immune, 1'b0);
        chk({tag, "_mvr_end"}, mv_right, 1'b1);
        chk({tag, "_blink_end"}, blink, 1'b1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hit = 1'b0; req_left = 1'b0; req_right = 1'b1; req_jump = 1'b0;
    #1;
    step(); step();
    chk("rst_frozen", frozen, 1'b0);
    chk("rst_immune", immune, 1'b0);
    chk("rst_mvr", mv_right, 1'b0);
    chk("rst_mvl", mv_left, 1'b0);
    chk("rst_blink", blink, 1'b1);

    rst = 1'b0;
    chk("idle_lag_before", mv_right, 1'b0);
    step();
    chk("idle_mvr", mv_right, 1'b1);
    req_jump = 1'b1;
    chk("jump_lag", mv_jump, 1'b0);
    step();
    chk("jump_follow", mv_jump, 1'b1);
    req_jump = 1'b0;
    step();
    chk("jump_drop", mv_jump, 1'b0);
    chk("idle_frozen", frozen, 1'b0);

    freeze_seq("pulse", 1, -1, -1);
    hit = 1'b0;
    step();
    chk("pulse_idle_frozen", frozen, 1'b0);

    // Held contact: single sequence, then no re-freeze while still held
    freeze_seq("held", 20, -1, -1);
    for (int k = 13; k < 20; k++) begin
      step();
      chk("held_no_refreeze", frozen, 1'b0);
      chk("held_no_immune", immune, 1'b0);
    end
    hit = 1'b0;
    step();
    chk("held_release", frozen, 1'b0);
    freeze_seq("rehold", 1, -1, -1);
    hit = 1'b0;
    step();

    // Re-hit during FROZEN and GRACE must not extend either phase
    freeze_seq("rehit", 1, 3, 9);
    hit = 1'b0;
    step();

    // Edge coinciding with the last GRACE cycle is dropped
    freeze_seq("lastgrace", 1, 12, -1);
    hit = 1'b1;
    step();
    chk("lastgrace_ignored", frozen, 1'b0);
    hit = 1'b0;
    step();
    chk("lastgrace_idle", frozen, 1'b0);

    // Reset in the fifth frozen cycle
    hit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      hit = 1'b0;
      chk("rstmid_frozen", frozen, 1'b1);
    end
    rst = 1'b1;
    step();
    chk("rstmid_frozen_clr", frozen, 1'b0);
    chk("rstmid_immune_clr", immune, 1'b0);
    chk("rstmid_mvr_clr", mv_right, 1'b0);
    rst = 1'b0;
    step();
    chk("rstmid_idle_frozen", frozen, 1'b0);
    chk("rstmid_idle_mvr", mv_right, 1'b1);
    freeze_seq("afterrst", 1, -1, -1);
    hit = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
